// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   rx_state_e - receiver FSM states
//   OS_RATE    - oversample ticks per bit
//   OS_MID     - oversample count at which the start bit is mid-sampled
//   os_div     - clocks per oversample tick (integer truncation)
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned OS_RATE = 16;
  localparam int unsigned OS_MID  = 7;

  function automatic int unsigned os_div(input int unsigned clk_freq,
                                         input int unsigned baud_rate);
    return clk_freq / (baud_rate * OS_RATE);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel output bus of uart_rx towards the receive-side consumer.
// Signals:
//   data_out   - last received word, held until the next frame completes
//   data_valid - one-clock pulse per completed frame
//   frame_err  - stop bit sampled low (qualified by data_valid)
//   parity_err - even-parity mismatch (qualified by data_valid)
//   busy       - a frame is in progress
// Modports: master (receiver side), slave (consumer side).
interface uart_rx_if #(
  parameter int unsigned N = 8
) ();

  logic [N-1:0] data_out;
  logic         data_valid;
  logic         frame_err;
  logic         parity_err;
  logic         busy;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input data_out,
    input data_valid,
    input frame_err,
    input parity_err,
    input busy
  );

endinterface

// File: rtl/uart_rx_os_tick.sv
// 16x oversample tick generator for uart_rx.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   clear - synchronous restart of the divider (aligns tick phase to a frame)
//   tick  - one-clock pulse every Div clocks
module uart_rx_os_tick #(
  parameter int unsigned Div = 325
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CntW'(Div - 1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, mid-bit sampling, stop-bit check and
// optional even-parity check. Frame: start(0), N data bits LSB-first,
// [parity], M stop bits(1).
// Optional feature: define UART_RX_PARITY_EN to compile in the parity bit
// and its checker; otherwise parity_err is tied low.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   rx    - serial line (asynchronous, idles high)
//   bus   - uart_rx_if.master: data_out, data_valid, frame_err, parity_err, busy
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned M         = 1,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLK_FREQ  = 50000000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned DIV     = os_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BitCntW = $clog2(N + 1);

  if (DIV < 2) begin : g_div_check
    $fatal(1, "uart_rx: CLK_FREQ/(BAUD_RATE*16) must be at least 2");
  end

  // Synchronizer plus one history flop for edge detection. Reset to the idle
  // level so leaving reset never looks like a start edge.
  logic rx_s1, rx_s2, rx_prev;
  logic fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Needs a high before the low, so a stuck-low line cannot retrigger.
  assign fall = rx_prev & ~rx_s2;

  rx_state_e          state;
  logic [3:0]         os_cnt;
  logic [BitCntW-1:0] bit_cnt;
  logic [N-1:0]       shift;
  logic [N-1:0]       data_out_q;
  logic               data_valid_q;
  logic               frame_acc;
  logic               frame_err_q;
  logic               busy_q;
  logic               tick;
  logic               div_clear;

  assign div_clear = (state == StIdle) && fall;

  uart_rx_os_tick #(
    .Div (DIV)
  ) u_os_tick (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_acc;
  logic parity_err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= StIdle;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_acc    <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_acc   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (fall) begin
            state  <= StStart;
            os_cnt <= '0;
            busy_q <= 1'b1;
          end
        end

        StStart: begin
          if (tick) begin
            if (os_cnt == 4'(OS_MID)) begin
              os_cnt <= '0;
              if (rx_s2) begin
                // Line back high at mid-start: glitch, not a frame.
                state  <= StIdle;
                busy_q <= 1'b0;
              end else begin
                state     <= StData;
                bit_cnt   <= '0;
                frame_acc <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end

        StData: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'(OS_RATE - 1)) begin
              // MSB-in shifting leaves the LSB-first word aligned after N bits.
              shift <= {rx_s2, shift[N-1:1]};
              if (bit_cnt == BitCntW'(N - 1)) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= StParity;
`else
                state   <= StStop;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'(OS_RATE - 1)) begin
              parity_acc <= rx_s2 ^ (^shift);
              state      <= StStop;
            end
          end
        end
`endif

        StStop: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'(OS_RATE - 1)) begin
              if (bit_cnt == BitCntW'(M - 1)) begin
                // Leave at mid-stop so a back-to-back start edge is caught.
                data_out_q   <= shift;
                data_valid_q <= 1'b1;
                frame_err_q  <= frame_acc | ~rx_s2;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= parity_acc;
`endif
                busy_q       <= 1'b0;
                state        <= StIdle;
                os_cnt       <= '0;
                bit_cnt      <= '0;
              end else begin
                frame_acc <= frame_acc | ~rx_s2;
                bit_cnt   <= bit_cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          state  <= StIdle;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: DIV=10, 160 clocks per bit, 8N1
// (8 data bits + even parity when UART_RX_PARITY_EN is defined).
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 160;

  logic clk;
  logic reset;
  logic rx;

  uart_rx_if #(.N(8)) bus ();

  uart_rx #(
    .N         (8),
    .M         (1),
    .BAUD_RATE (10000),
    .CLK_FREQ  (1600000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Captured frames: {parity_err, frame_err, data_out}
  logic [9:0] caps[$];
  int         dv_wide;
  logic       dv_prev;
  logic       busy_n2;
  logic       busy_n3;

  initial begin
    dv_wide = 0;
    dv_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.data_valid) begin
      caps.push_back({bus.parity_err, bus.frame_err, bus.data_out});
      if (dv_prev) dv_wide <= dv_wide + 1;
    end
    dv_prev <= bus.data_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // bad_par flips the parity bit away from even parity; stop_v is the stop level.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_v);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    busy_n2 = bus.busy;
    @(negedge clk);
    busy_n3 = bus.busy;
    repeat (BIT_CLKS - 3) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop_v);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe,
                              input logic pe);
    logic [9:0] c;
    check({tag, "_avail"}, 32'(caps.size() != 0), 32'd1);
    if (caps.size() != 0) begin
      c = caps.pop_front();
      check({tag, "_data"}, 32'(c[7:0]), 32'(d));
      check({tag, "_ferr"}, 32'(c[8]), 32'(fe));
      check({tag, "_perr"}, 32'(c[9]), 32'(pe));
    end
  endtask

  task automatic expect_none(input string tag);
    check({tag, "_none"}, 32'(caps.size()), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    rx       = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_dv", 32'(bus.data_valid), 32'h0);
    check("rst_ferr", 32'(bus.frame_err), 32'h0);
    check("rst_perr", 32'(bus.parity_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Clean 0xA5 frame, including busy latency from the pin edge.
    send_frame(8'hA5, 1'b0, 1'b1);
    check("a5_busy_n2", 32'(busy_n2), 32'd0);
    check("a5_busy_n3", 32'(busy_n3), 32'd1);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    expect_none("a5_extra");
    check("a5_busy_after", 32'(bus.busy), 32'd0);
    repeat (100) @(negedge clk);

    // 40-clock low glitch from idle.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy", 32'(bus.busy), 32'd1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_busy_after", 32'(bus.busy), 32'd0);
    expect_none("glitch");
    check("glitch_data_held", 32'(bus.data_out), 32'hA5);

    // Stop bit low, then line stays low: one errored frame, no retrigger.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    expect_frame("ferr", 8'h3C, 1'b1, 1'b0);
    expect_none("ferr_stuck");
    check("ferr_busy_stuck", 32'(bus.busy), 32'd0);
    rx = 1'b1;
    repeat (320) @(negedge clk);
    expect_none("ferr_rise");

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd popcount, so the even-parity bit is 1.
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame("par_bad", 8'h07, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    send_frame(8'h07, 1'b0, 1'b1);
    expect_frame("par_good", 8'h07, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
`endif

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    expect_frame("b2b_0", 8'h00, 1'b0, 1'b0);
    expect_frame("b2b_1", 8'hFF, 1'b0, 1'b0);
    expect_none("b2b_extra");
    repeat (50) @(negedge clk);

    // Reset in the middle of bit 4 of 0x55, then a clean 0x81.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_data", 32'(bus.data_out), 32'h0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (400) @(negedge clk);
    expect_none("abort");
    send_frame(8'h81, 1'b0, 1'b1);
    expect_frame("after_abort", 8'h81, 1'b0, 1'b0);
    expect_none("after_abort_extra");
    repeat (50) @(negedge clk);

    check("dv_one_cycle", 32'(dv_wide), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Asynchronous serial receiver: the downstream counterpart of the team's `uart_tx`.
- Recovers frames using 16x oversampling with mid-bit sampling and checks stop bits (and parity when compiled in).
- Presents each received word on a parallel bus with a one-cycle valid pulse.
- Sits between the board RX pin and the receive-side consumer (FIFO or command decoder).
- Frame format matches `uart_tx`: one start bit (low), N data bits LSB-first, an optional even-parity bit, and M stop bits (high).

## Interface
- `N`, 8, data bits per frame
- `M`, 1, stop bits per frame (1 or 2)
- `BAUD_RATE`, 9600, line rate in bit/s
- `CLK_FREQ`, 50000000, `clk` frequency in Hz
- `clk`  in  1  single system clock; all logic is on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `rx`  in  1  serial line, asynchronous to `clk`; idles high
- `data_out`  out  N  last received word; holds its value until the next frame completes
- `data_valid`  out  1  one-`clk` pulse when a frame completes
- `frame_err`  out  1  a stop bit was sampled low; meaningful only while `data_valid`=1
- `parity_err`  out  1  parity mismatch; meaningful only while `data_valid`=1; tied 0 without the macro
- `busy`  out  1  high from start-bit detection until the frame ends or is aborted

## Operation
- `rx` passes through a 2-flop synchronizer. A third flop holds the previous value for edge detection.
- Oversample tick:
  - `DIV = CLK_FREQ/(BAUD_RATE*16)`, integer truncation (default gives 325).
  - Tick is one `clk` wide every `DIV` clocks.
  - The divider counter is cleared on start-edge detection, so tick phase aligns to each frame.
- A 4-bit oversample counter `os_cnt` counts ticks within a bit.
- A bit counter counts data bits and stop bits.
- States:
  - IDLE: `busy`=0. A falling edge on synchronized `rx` goes to START, clears `os_cnt` and the divider, and sets `busy`=1. A line held low, for example a break or a stuck-low line, never retriggers; a high must be seen first.
  - START: at `os_cnt`=7 (mid-bit), if `rx`=1 treat the edge as a glitch: go to IDLE, `busy`=0, no output. Otherwise clear `os_cnt` and go to DATA.
  - DATA: at each `os_cnt`=15 wrap (mid-bit), shift `rx` into the MSB of the shift register, so LSB-first arrival ends aligned. After the N-th bit, go to PARITY if compiled in, else STOP.
  - PARITY: sample at mid-bit. The error flag is `rx` XOR (XOR-reduction of the data), i.e. even parity, matching the `^data_in` generation in `uart_tx`. Then go to STOP.
  - STOP: sample each of the M stop bits at mid-bit and OR any low sample into the frame-error flag. At the mid-sample of the last stop bit:
    - load `data_out`;
    - pulse `data_valid`, with `frame_err`/`parity_err`;
    - drop `busy`;
    - go to IDLE.
- Returning to IDLE at mid-stop-bit allows a back-to-back start edge half a bit later.
- A frame with errors is still delivered; the consumer decides whether to discard it.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0. State is IDLE and all counters are 0.
- Reset may be asserted mid-frame. It aborts immediately with no `data_valid`, and the receiver re-arms on the next falling edge after release.
- `busy` rises 3 clocks after the `rx` falling edge at the pin: 2 synchronizer clocks plus 1 registered-detect clock.
- `data_valid` rises on the clock after the last stop-bit mid-sample. It is exactly 1 clock wide, and `frame_err`/`parity_err` are valid in the same cycle.
- Sample point error is at most ±1 oversample tick plus 3 clocks. The tolerated baud mismatch is about ±3% for 10-bit frames.
- `DIV` must be at least 2. This is an elaboration-time check; violation is a fatal elaboration error.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state compiled in, frame length is 1+N+1+M.
  - `parity_err` is driven as described above.
- Undefined:
  - PARITY state and its checker are absent, frame length is 1+N+M.
  - `parity_err` is a constant 0.
- Must match the `PARITY_EN` setting of the paired `uart_tx`.

## Structure
- Shared package `uart_pkg`:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP);
  - `OS_RATE`=16;
  - `OS_MID`=7.
- One sub-module, `uart_rx_os_tick`:
  - the 16x divider with a synchronous `clear` input and a `tick` output;
  - same `clk`/`reset` convention.
- The synchronizer, FSM, shift register and flags stay in `uart_rx`.

## Test plan
Bench parameters: `CLK_FREQ`=1600000, `BAUD_RATE`=10000, giving `DIV`=10 and 160 clocks per bit.
- Send 0xA5 with one stop bit → exactly one `data_valid`, `data_out`=0xA5, `frame_err`=0, `busy` low afterwards.
- Low glitch on `rx` of 40 clocks from idle → `busy` pulses, then returns to 0; no `data_valid`; `data_out` unchanged.
- Send 0x3C with the stop bit held low, then hold `rx` low → `data_valid` with `frame_err`=1 and `data_out`=0x3C; no further frame until `rx` goes high and then falls.
- With the macro: send 0x07 with parity bit 0 → `parity_err`=1. Send 0x07 with parity bit 1 → `parity_err`=0.
- Frames 0x00 then 0xFF back-to-back with no idle gap → two `data_valid` pulses, 0x00 then 0xFF, no errors.
- Assert reset during bit 4 of 0x55, release, then send 0x81 → no output for the aborted frame; one `data_valid` with 0x81.
